mealy_state_machine: RTL and testbench

// - Two-state Mealy FSM detecting transitions (rising or falling) on a 1-bit serial input.
// - Registered state tracks the last sampled input level.
// - Output is combinational from current state and live input: one-cycle, same-cycle edge flag.
// - Used as a small edge/toggle detector ahead of event counters or handshake logic.
//

---
 rtl/mealy_state_machine.sv | 64 ++++++
 tb/tb_mealy_state_machine.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mealy_state_machine.sv
// Two-state Mealy edge detector: the state flop remembers the last sampled
// input level, and out flags any difference between the live input and that
// remembered level in the same cycle it appears.
module mealy_state_machine #(
  parameter logic RESET_STATE = 1'b0
) (
  input  logic clk,
  input  logic reset,   // asynchronous, active-low
  input  logic in,
  output logic state,
  output logic out
);

  typedef enum logic {
    S0 = 1'b0,  // input last seen low
    S1 = 1'b1   // input last seen high
  } state_t;

  localparam state_t RESET_ENC = state_t'(RESET_STATE);

  state_t state_reg;
  state_t state_next;
  logic   out_next;

  // State register: captures the input level each edge, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RESET_ENC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state follows the input; out flags a pending transition, gated by reset.
  always_comb begin
    state_next = state_reg;
    out_next   = 1'b0;
    unique case (state_reg)
      S0: begin
        if (in) begin
          state_next = S1;
          out_next   = 1'b1;  // rising transition
        end
      end
      S1: begin
        if (!in) begin
          state_next = S0;
          out_next   = 1'b1;  // falling transition
        end
      end
      default: begin
        state_next = S0;
        out_next   = 1'b0;
      end
    endcase
    if (!reset) begin
      out_next = 1'b0;
    end
  end

  assign state = state_reg;
  assign out   = out_next;

endmodule

// File: tb/tb_mealy_state_machine.sv
// Bench for the Mealy edge detector: directed scenarios followed by random
// input/reset traffic, checked against a model that keeps the history of
// sampled input levels.
module tb_mealy_state_machine;

  localparam logic RESET_STATE = 1'b0;

  logic clk;
  logic reset;
  logic in;
  logic state;
  logic out;

  int vectors;
  int miscompares;

  // Reference model: levels sampled on clock edges since the last reset.
  logic level_hist[$];

  mealy_state_machine #(.RESET_STATE(RESET_STATE)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .state (state),
    .out   (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic model_level();
    if (level_hist.size() == 0) return RESET_STATE;
    return level_hist[$];
  endfunction

  function automatic logic model_out();
    if (reset !== 1'b1) return 1'b0;
    return (in != model_level()) ? 1'b1 : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive at the falling edge, check before and after the rising edge.
  task automatic step(input logic in_v, input logic rst_v, input string tag);
    @(negedge clk);
    reset = rst_v;
    in    = in_v;
    if (!rst_v) level_hist.delete();
    #1;
    chk({tag, ".pre_state"}, state, model_level());
    chk({tag, ".pre_out"},   out,   model_out());
    @(posedge clk);
    if (reset) level_hist.push_back(in);
    #1;
    chk({tag, ".post_state"}, state, model_level());
    chk({tag, ".post_out"},   out,   model_out());
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset asserted with in=1 before any clock edge.
    reset = 1'b0;
    in    = 1'b1;
    #3;
    chk("reset.state_no_clk", state, RESET_STATE);
    chk("reset.out_forced",   out,   1'b0);

    // Release with in low.
    step(1'b0, 1'b1, "release");

    // Rising transition from S0.
    step(1'b1, 1'b1, "rise");
    // Falling transition from S1.
    step(1'b0, 1'b1, "fall");

    // Hold high three cycles: only the first flags.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $sformatf("hold%0d", i));

    // Alternate each cycle: every cycle flags.
    step(1'b0, 1'b1, "alt0");
    for (int i = 0; i < 4; i++) step(i[0] ? 1'b0 : 1'b1, 1'b1, $sformatf("alt%0d", i + 1));

    // Mid-run reset from S1: state clears immediately without a clock edge.
    step(1'b1, 1'b1, "pre_rst");
    @(negedge clk);
    #2;
    reset = 1'b0;
    level_hist.delete();
    #1;
    chk("midrst.state_async", state, RESET_STATE);
    chk("midrst.out_forced",  out,   1'b0);
    step(1'b1, 1'b0, "midrst.hold");
    step(1'b0, 1'b1, "midrst.release");

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      logic in_r;
      logic rst_r;
      in_r  = 1'($urandom_range(0, 1));
      rst_r = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
      step(in_r, rst_r, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
